// File: rtl/sweep_checker.sv
// Exhaustive truth-table sweeper/self-checker for a combinational DUT.
// Latency: start seen at edge T -> vec=0, busy=1 after T; busy lasts 2^N_IN*HOLD cycles.
// Backpressure: none; start is ignored while a sweep is in progress.
//
// Ports: clk/rst_n (sync, active-low); start begins a sweep from IDLE or DONE;
// dut_out is the DUT response; vec drives the DUT inputs; busy/done/pass give
// sweep status; err_count, first_fail_valid, first_fail_idx report mismatches.
module sweep_checker #(
  parameter int                        N_IN   = 4,
  parameter int                        HOLD   = 2,
  parameter logic [(2**N_IN)-1:0]      EXPECT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  // Hold counter needs at least one bit even when HOLD=1.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int EW = N_IN + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [EW-1:0]   err_q, err_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffi_q, ffi_d;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
        end
      end
      DRIVE: begin
        if (hold_q == HW'(HOLD - 1)) begin
          // Last edge of the hold window: sample the settled DUT output.
          if (dut_out != EXPECT[vec_q]) begin
            err_d = err_q + EW'(1);
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = vec_q;
            end
          end
          // The terminal vector ends the sweep instead of wrapping.
          if (&vec_q) begin
            state_d = DONE;
          end else begin
            vec_d  = vec_q + N_IN'(1);
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
    end
  end

  assign vec              = vec_q;
  assign busy             = (state_q == DRIVE);
  assign done             = (state_q == DONE);
  assign pass             = (state_q == DONE) && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_sweep_checker.sv
module tb_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // 4-input instance: golden table 16'hA5C3, HOLD=2
  logic        start4;
  logic        dut_out4;
  logic [3:0]  vec4;
  logic        busy4, done4, pass4, ffv4;
  logic [4:0]  err4;
  logic [3:0]  ffi4;
  logic [1:0]  mode_r;   // 0: correct DUT, 1: wrong at 5 and 12, 2: fully inverted
  logic [15:0] tbl4;

  // 2-input instance: XOR DUT, HOLD=1
  logic        start2;
  logic        dut_out2;
  logic [1:0]  vec2;
  logic        busy2, done2, pass2, ffv2;
  logic [2:0]  err2;
  logic [1:0]  ffi2;

  sweep_checker #(.N_IN(4), .HOLD(2), .EXPECT(16'hA5C3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dut_out(dut_out4),
    .vec(vec4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .first_fail_valid(ffv4), .first_fail_idx(ffi4)
  );

  sweep_checker #(.N_IN(2), .HOLD(1), .EXPECT(4'b0110)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_out(dut_out2),
    .vec(vec2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_valid(ffv2), .first_fail_idx(ffi2)
  );

  assign dut_out4 = tbl4[vec4] ^ (mode_r == 2'd2)
                  ^ ((mode_r == 2'd1) && (vec4 == 4'd5 || vec4 == 4'd12));
  assign dut_out2 = vec2[1] ^ vec2[0];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int mode;
    bit pulse_mid;
    int e_err;
    int e_ffv;
    int e_ffi;
    int e_pass;
  } vec_rec_t;

  // One full sweep of the 4-input instance; optionally pulses start at vec=3.
  task automatic run_sweep(input vec_rec_t r);
    int cyc;
    int vbad;
    bit pulsed;
    mode_r = 2'(r.mode);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("busy_after_start", int'(busy4), 1);
    chk("done_after_start", int'(done4), 0);
    chk("err_cleared", int'(err4), 0);
    chk("ffv_cleared", int'(ffv4), 0);
    cyc = 0; vbad = 0; pulsed = 0;
    while (busy4 && cyc < 200) begin
      if (int'(vec4) != cyc / 2) vbad++;
      if (done4 || pass4) vbad++;
      if (r.pulse_mid && !pulsed && vec4 == 4'd3) begin
        start4 = 1'b1;
        pulsed = 1'b1;
      end else begin
        start4 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start4 = 1'b0;
    chk("busy_cycles", cyc, 32);
    chk("vec_sequence_errs", vbad, 0);
    chk("done", int'(done4), 1);
    chk("busy_end", int'(busy4), 0);
    chk("vec_last", int'(vec4), 15);
    chk("err_count", int'(err4), r.e_err);
    chk("first_fail_valid", int'(ffv4), r.e_ffv);
    chk("first_fail_idx", int'(ffi4), r.e_ffi);
    chk("pass", int'(pass4), r.e_pass);
  endtask

  initial begin
    vec_rec_t tbl[4];
    int k;
    int cyc;
    int vbad;

    tbl4   = 16'hA5C3;
    mode_r = 2'd0;
    start2 = 1'b0;
    // Reset dominates a simultaneous start.
    rst_n  = 1'b0;
    start4 = 1'b1;
    repeat (2) @(negedge clk);
    start4 = 1'b0;
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_pass", int'(pass4), 0);
    chk("rst_vec", int'(vec4), 0);
    chk("rst_err", int'(err4), 0);
    chk("rst_ffv", int'(ffv4), 0);
    chk("rst_ffi", int'(ffi4), 0);
    chk("rst_busy2", int'(busy2), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stays_idle", int'(busy4), 0);

    //            mode pulse err ffv ffi pass
    tbl[0] = '{1, 1'b0,  2, 1,  5, 0};
    tbl[1] = '{2, 1'b1, 16, 1,  0, 0};
    tbl[2] = '{0, 1'b0,  0, 0,  0, 1};
    tbl[3] = '{1, 1'b1,  2, 1,  5, 0};
    for (int i = 0; i < 4; i++) begin
      run_sweep(tbl[i]);
      repeat (2) @(negedge clk);
      chk("done_holds", int'(done4), 1);
    end

    // Reset mid-sweep at vec=7 with errors already counted.
    mode_r = 2'd2;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    k = 0;
    while (vec4 != 4'd7 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach_vec7", int'(vec4), 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", int'(busy4), 0);
    chk("midrst_done", int'(done4), 0);
    chk("midrst_pass", int'(pass4), 0);
    chk("midrst_vec", int'(vec4), 0);
    chk("midrst_err", int'(err4), 0);
    chk("midrst_ffv", int'(ffv4), 0);
    chk("midrst_ffi", int'(ffi4), 0);
    @(negedge clk);
    chk("midrst_stays_idle", int'(busy4), 0);
    run_sweep('{0, 1'b0, 0, 0, 0, 1});

    // 2-input XOR with HOLD=1: one cycle per vector.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0; vbad = 0;
    while (busy2 && cyc < 50) begin
      if (int'(vec2) != cyc) vbad++;
      @(negedge clk);
      cyc++;
    end
    chk("n2_busy_cycles", cyc, 4);
    chk("n2_vec_sequence_errs", vbad, 0);
    chk("n2_done", int'(done2), 1);
    chk("n2_pass", int'(pass2), 1);
    chk("n2_err", int'(err2), 0);
    chk("n2_vec_last", int'(vec2), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
